jump_field_encoder: RTL and testbench

// - Inverse of the jump-target calculation: takes an absolute 32-bit jump target and PC+4, emits the
//   26-bit J-type index and full J/JAL instruction word, and flags unencodable targets.
// - Sits in the assembler/self-modifying-code path beside the single-cycle core; a valid/ready

---
 rtl/jump_field_encoder.sv | 112 +++++++++++
 tb/tb_jump_field_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_field_encoder.sv
// J/JAL encoder: absolute jump target + PC+4 -> 26-bit index and instruction word.
// Optional FAULT_COUNT_EN adds a saturating count of faulting responses.
module jump_field_encoder #(
  parameter logic [5:0] J_OPCODE   = 6'b000010,
  parameter logic [5:0] JAL_OPCODE = 6'b000011,
  parameter int         CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] Target,
  input  logic [31:0] PC_4,
  input  logic        Link,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [25:0] Jump_field,
  output logic [31:0] Instr,
  output logic        Exception,
  output logic [1:0]  Exc_cause
`ifdef FAULT_COUNT_EN
  ,
  output logic [CNT_W-1:0] Fault_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP
  } state_t;

  state_t state, state_n;

  logic [31:0] tgt;
  logic [3:0]  pc_hi;
  logic        link_q;
  logic [1:0]  cause_c;

  // Only the region nibble of PC+4 matters; it is never alignment-checked.
  logic unused_pc;
  assign unused_pc = ^PC_4[27:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = CHECK;
      CHECK:   state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt    <= '0;
      pc_hi  <= '0;
      link_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      tgt    <= Target;
      pc_hi  <= PC_4[31:28];
      link_q <= Link;
    end
  end

  assign cause_c = {tgt[31:28] != pc_hi, tgt[1:0] != 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      Jump_field <= '0;
      Instr      <= '0;
      Exception  <= 1'b0;
      Exc_cause  <= 2'b00;
    end else if (state == CHECK) begin
      Exc_cause <= cause_c;
      Exception <= |cause_c;
      if (|cause_c) begin
        Jump_field <= '0;
        Instr      <= '0;
      end else begin
        Jump_field <= tgt[27:2];
        Instr      <= {link_q ? JAL_OPCODE : J_OPCODE, tgt[27:2]};
      end
    end
  end

`ifdef FAULT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Fault_count <= '0;
    end else if (state == RESP && resp_ready && Exception
                 && Fault_count != {CNT_W{1'b1}}) begin
      Fault_count <= Fault_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_jump_field_encoder.sv
// Self-checking bench for jump_field_encoder: vector table, corner sequences,
// and randomized requests against an arithmetic reference model.
module tb_jump_field_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] Target;
  logic [31:0] PC_4;
  logic        Link;
  logic        resp_valid;
  logic        resp_ready;
  logic [25:0] Jump_field;
  logic [31:0] Instr;
  logic        Exception;
  logic [1:0]  Exc_cause;
`ifdef FAULT_COUNT_EN
  logic [15:0] Fault_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jump_field_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .Target     (Target),
    .PC_4       (PC_4),
    .Link       (Link),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .Jump_field (Jump_field),
    .Instr      (Instr),
    .Exception  (Exception),
    .Exc_cause  (Exc_cause)
`ifdef FAULT_COUNT_EN
    ,
    .Fault_count(Fault_count)
`endif
  );

  typedef struct {
    logic [31:0] target;
    logic [31:0] pc4;
    logic        link;
    logic [25:0] jf;
    logic [31:0] instr;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the encoding rules.
  task automatic model(input logic [31:0] t, input logic [31:0] p,
                       input logic l, output logic [25:0] jf,
                       output logic [31:0] ins, output logic [1:0] cause);
    int unsigned field;
    cause[0] = (t % 4) != 0;
    cause[1] = (t / 32'h1000_0000) != (p / 32'h1000_0000);
    field = (t / 4) % (1 << 26);
    if (cause != 2'b00) begin
      jf  = '0;
      ins = '0;
    end else begin
      jf  = field[25:0];
      ins = (l ? 32'd3 : 32'd2) * 32'h0400_0000 + field;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    chk("req_ready_in_reset", {31'd0, req_ready}, 32'd0);
    step();
    reset = 1'b0;
    step();
  endtask

  // One request through the full handshake; returns the response outputs.
  task automatic txn(input logic [31:0] t, input logic [31:0] p,
                     input logic l, output logic [25:0] jf,
                     output logic [31:0] ins, output logic ex,
                     output logic [1:0] cause);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b1;
    Target    = t;
    PC_4      = p;
    Link      = l;
    step();
    req_valid = 1'b0;
    Target    = $urandom;
    PC_4      = $urandom;
    Link      = 1'($urandom);
    chk("check_req_ready", {31'd0, req_ready}, 32'd0);
    chk("check_resp_valid", {31'd0, resp_valid}, 32'd0);
    step();
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    jf    = Jump_field;
    ins   = Instr;
    ex    = Exception;
    cause = Exc_cause;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [25:0] jf, ejf;
    logic [31:0] ins, eins;
    logic        ex;
    logic [1:0]  cause, ecause;
    logic [31:0] t, p;
    logic [25:0] hold_jf;
    logic [31:0] hold_ins;

    vecs[0] = '{32'h9012_3454, 32'h9000_0000, 1'b0, 26'h004_8D15, 32'h0804_8D15, 2'b00};
    vecs[1] = '{32'h9012_3454, 32'h9000_0000, 1'b1, 26'h004_8D15, 32'h0C04_8D15, 2'b00};
    vecs[2] = '{32'h0000_0002, 32'h0000_0000, 1'b0, 26'h0, 32'h0, 2'b01};
    vecs[3] = '{32'hF000_0000, 32'h1000_0000, 1'b0, 26'h0, 32'h0, 2'b10};
    vecs[4] = '{32'hF000_0001, 32'h1000_0000, 1'b1, 26'h0, 32'h0, 2'b11};
    vecs[5] = '{32'h3000_0000, 32'h3ABC_DEF3, 1'b1, 26'h0, 32'h0C00_0000, 2'b00};
    vecs[6] = '{32'h3FFF_FFFC, 32'h3000_0000, 1'b0, 26'h3FF_FFFF, 32'h0BFF_FFFF, 2'b00};
    vecs[7] = '{32'h4000_0000, 32'h3FFF_FFFC, 1'b0, 26'h0, 32'h0, 2'b10};

    req_valid  = 1'b0;
    resp_ready = 1'b0;
    Target     = '0;
    PC_4       = '0;
    Link       = 1'b0;
    do_reset();
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_jf", {6'd0, Jump_field}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_exc", {29'd0, Exception, Exc_cause}, 32'd0);

    foreach (vecs[i]) begin
      txn(vecs[i].target, vecs[i].pc4, vecs[i].link, jf, ins, ex, cause);
      chk($sformatf("vec%0d_jf", i), {6'd0, jf}, {6'd0, vecs[i].jf});
      chk($sformatf("vec%0d_instr", i), ins, vecs[i].instr);
      chk($sformatf("vec%0d_cause", i), {30'd0, cause}, {30'd0, vecs[i].cause});
      chk($sformatf("vec%0d_exc", i), {31'd0, ex}, {31'd0, vecs[i].cause != 2'b00});
      if (vecs[i].cause == 2'b00)
        chk($sformatf("vec%0d_roundtrip", i), {vecs[i].pc4[31:28], jf, 2'b00},
            vecs[i].target);
    end

    // Backpressure: response held, stray request ignored.
    txn_start: begin
      req_valid = 1'b1;
      Target    = 32'h9012_3454;
      PC_4      = 32'h9000_0000;
      Link      = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      hold_jf  = Jump_field;
      hold_ins = Instr;
      chk("bp_instr_first", hold_ins, 32'h0C04_8D15);
      for (int c = 0; c < 5; c++) begin
        if (c == 2) begin
          req_valid = 1'b1;
          Target    = 32'h5555_5555;
          PC_4      = 32'h1000_0000;
        end else begin
          req_valid = 1'b0;
        end
        step();
        chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_jf_hold", {6'd0, Jump_field}, {6'd0, hold_jf});
        chk("bp_instr_hold", Instr, hold_ins);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("bp_release_idle", {30'd0, req_ready, resp_valid}, 32'd2);
      for (int c = 0; c < 3; c++) begin
        step();
        chk("bp_no_stray", {31'd0, resp_valid}, 32'd0);
      end
    end

    // Reset while in CHECK drops the request.
    req_valid = 1'b1;
    Target    = 32'h9012_3454;
    PC_4      = 32'h9000_0000;
    step();
    req_valid = 1'b0;
    reset     = 1'b1;
    step();
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_instr", Instr, 32'd0);
    chk("midrst_jf", {6'd0, Jump_field}, 32'd0);
    chk("midrst_exc", {29'd0, Exception, Exc_cause}, 32'd0);
    reset = 1'b0;
    step();
    chk("midrst_idle", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // Randomized requests against the reference model.
    for (int n = 0; n < 200; n++) begin
      p = $urandom;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[31:28] = p[31:28];
      if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
      Link = 1'($urandom);
      model(t, p, Link, ejf, eins, ecause);
      txn(t, p, Link, jf, ins, ex, cause);
      chk("rnd_jf", {6'd0, jf}, {6'd0, ejf});
      chk("rnd_instr", ins, eins);
      chk("rnd_cause", {30'd0, cause}, {30'd0, ecause});
      chk("rnd_exc", {31'd0, ex}, {31'd0, ecause != 2'b00});
    end

`ifdef FAULT_COUNT_EN
    do_reset();
    chk("fc_reset", {16'd0, Fault_count}, 32'd0);
    txn(32'h0000_0002, 32'h0000_0000, 1'b0, jf, ins, ex, cause);
    txn(32'h1000_0004, 32'h1000_0000, 1'b0, jf, ins, ex, cause);
    txn(32'hF000_0000, 32'h1000_0000, 1'b0, jf, ins, ex, cause);
    txn(32'h2000_0008, 32'h2000_0000, 1'b1, jf, ins, ex, cause);
    txn(32'hF000_0001, 32'h1000_0000, 1'b1, jf, ins, ex, cause);
    chk("fc_three", {16'd0, Fault_count}, 32'd3);
    @(negedge clk);
    force dut.Fault_count = 16'hFFFF;
    @(negedge clk);
    release dut.Fault_count;
    step();
    txn(32'h0000_0003, 32'h0000_0000, 1'b0, jf, ins, ex, cause);
    chk("fc_saturate", {16'd0, Fault_count}, 32'h0000_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
